// File: rtl/rng_pkg.sv
// Shared definitions for the cactus-scheduling random source.
// Holds the draw FSM state encoding, default Galois feedback masks and seeds
// for common LFSR widths, and the bit-smear helper that turns an inclusive
// limit into the smallest all-ones mask covering it.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_HOLD = 2'd2
    } rng_state_e;

    // Maximal-length Galois masks (right-shifting form) and nonzero seeds.
    localparam logic [7:0]  TAPS_8  = 8'hB8;          // x^8+x^6+x^5+x^4+1
    localparam logic [7:0]  SEED_8  = 8'h01;
    localparam logic [15:0] TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] SEED_16 = 16'h0001;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [31:0] SEED_32 = 32'h0000_0001;

    // Smallest 2^k-1 that is >= value: propagate the highest set bit downwards.
    // Callers narrow the 32-bit result to their own limit width.
    function automatic logic [31:0] smear_mask(input logic [31:0] value);
        logic [31:0] m;
        m = value;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with seed load and lock-up guard.
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset (to SEED)
//   step        - advance the register one position this cycle
//   load        - load load_value this cycle (wins over step); zero loads SEED
//   load_value  - seed to load
//   state       - current register contents
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] stepped_s;
    logic [WIDTH-1:0] next_s;

    // Next-state selection: load, then zero recovery, then step, else hold.
    always_comb begin
        stepped_s = (state >> 1) ^ (state[0] ? TAPS : {WIDTH{1'b0}});
        next_s    = state;
        if (load) begin
            // A zero seed would lock the register, so it is swapped for SEED.
            next_s = (load_value == {WIDTH{1'b0}}) ? SEED : load_value;
        end else if (state == {WIDTH{1'b0}}) begin
            next_s = SEED;
        end else if (step) begin
            next_s = stepped_s;
        end else begin
            next_s = state;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= next_s;
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Ranged pseudo-random draws for obstacle scheduling.
// A request for a value in [0, req_limit] is served by masking the LFSR low
// bits to the smallest covering power-of-two range and rejecting candidates
// above the limit; after MAX_TRY rejections a deterministic fold keeps the
// latency bounded.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   advance                           - stir the LFSR (player input)
//   seed_load, seed_in                - reseed the LFSR
//   req_valid, req_ready, req_limit   - draw request handshake
//   rsp_valid, rsp_ready, rsp_data    - draw result handshake
//   lfsr_state                        - raw LFSR state
module lfsr_rng import rng_pkg::*; #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS    = TAPS_16,
    parameter logic [WIDTH-1:0] SEED    = SEED_16,
    parameter int               OUT_W   = 5,
    parameter int               MAX_TRY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_limit,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int TRY_W = $clog2(MAX_TRY + 1);

    rng_state_e       state_r;
    logic [OUT_W-1:0] limit_r;
    logic [OUT_W-1:0] mask_r;
    logic [TRY_W-1:0] tries_r;

    logic             step_s;
    logic [OUT_W-1:0] cand_s;
    logic [OUT_W:0]   fold_wide_s;
    logic [OUT_W-1:0] fold_s;

    // In DRAW the draw step and advance coincide into a single step.
    assign step_s    = advance | (state_r == ST_DRAW);
    assign req_ready = (state_r == ST_IDLE);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .step       (step_s),
        .load       (seed_load),
        .load_value (seed_in),
        .state      (lfsr_state)
    );

    // Candidate and fallback fold. Since C <= M <= 2L+1, C-(L+1) <= L; the
    // extra bit only keeps L+1 from wrapping when L is all ones.
    always_comb begin
        cand_s      = lfsr_state[OUT_W-1:0] & mask_r;
        fold_wide_s = {1'b0, cand_s} - ({1'b0, limit_r} + {{OUT_W{1'b0}}, 1'b1});
        fold_s      = fold_wide_s[OUT_W-1:0];
    end

    // Draw FSM with registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            limit_r   <= {OUT_W{1'b0}};
            mask_r    <= {OUT_W{1'b0}};
            tries_r   <= {TRY_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_data  <= {OUT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        limit_r <= req_limit;
                        mask_r  <= OUT_W'(smear_mask(32'(req_limit)));
                        tries_r <= {TRY_W{1'b0}};
                        state_r <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (cand_s <= limit_r) begin
                        rsp_data  <= cand_s;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else if (tries_r < TRY_W'(MAX_TRY)) begin
                        tries_r <= tries_r + {{(TRY_W-1){1'b0}}, 1'b1};
                    end else begin
                        rsp_data  <= fold_s;
                        rsp_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised pseudo-random source for obstacle (cactus) scheduling. A WIDTH-bit Galois LFSR with seed load and lock-up guard serves ranged draws: the game FSM requests a value in [0, limit], and the block returns an unbiased result by rejection sampling over a valid/ready handshake. An `advance` input stirs the generator on player input, so the sequence depends on player timing.

## Interface
- WIDTH, 16, LFSR state width (≥ OUT_W, ≥ 4)
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
- SEED, 16'h0001, reset/fallback state; must be nonzero
- OUT_W, 5, width of limit and result
- MAX_TRY, 4, rejected candidates allowed before fallback (≥ 1)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- advance  in  1  step LFSR this cycle (jump button / free stir)
- seed_load  in  1  load seed_in into LFSR this cycle
- seed_in  in  WIDTH  seed value
- req_valid  in  1  draw request
- req_ready  out  1  high in IDLE only
- req_limit  in  OUT_W  inclusive upper bound of draw
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  OUT_W  drawn value, always ≤ latched limit
- lfsr_state  out  WIDTH  current LFSR state (debug / other consumers)

## Operation
- Step: next = (s >> 1) ^ (s[0] ? TAPS : 0). At most one step per cycle.
- LFSR update priority: seed_load > step. Step occurs if advance=1 or FSM in DRAW.
- seed_load with seed_in==0 loads SEED. Any zero state is replaced by SEED on the next edge.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch limit L and mask M, clear try count, go to DRAW.
  - DRAW: evaluate candidate C = lfsr_state[OUT_W-1:0] & M.
  - HOLD: rsp_valid=1. On rsp_ready, go to IDLE.
- M = smallest 2^k−1 ≥ L (bit-smear of L), so L ≤ M ≤ 2L+1.
- DRAW transitions:
  - C ≤ L: register rsp_data=C, go to HOLD.
  - C > L and tries < MAX_TRY: increment tries, stay in DRAW.
  - C > L and tries == MAX_TRY: rsp_data = C − (L+1), go to HOLD. This is deterministic and always ≤ L.
- The LFSR steps on every DRAW cycle, including the accepting one, so consecutive draws never reuse a state.
- L=0: M=0, C=0, accepted on the first try. L=2^OUT_W−1: always accepted on the first try.
- advance is ignored by the FSM. In DRAW, advance and the draw step coincide and produce a single step.
- seed_load during DRAW: the next candidate comes from the loaded state. No restart.
- rsp_data and the latched L/M are stable throughout HOLD. req_valid is ignored outside IDLE.
- rst mid-operation: FSM returns to IDLE, LFSR returns to SEED, and any in-flight draw is discarded.

## Timing
- Reset values: lfsr_state=SEED, rsp_valid=0, rsp_data=0, FSM=IDLE, req_ready=1.
- Request accepted on edge N → DRAW in cycle N+1 → rsp_valid high from cycle N+2 at the earliest.
- Each rejection adds 1 cycle. Worst-case latency is 2+MAX_TRY cycles.
- Response handshake completes on the edge where rsp_valid & rsp_ready. req_ready rises the following cycle, so there is no back-to-back accept in the same cycle.
- All outputs are registered except req_ready, which is decoded from the FSM state register.

## Structure
- Package rng_pkg holds:
  - FSM state enum (IDLE, DRAW, HOLD)
  - default TAPS/SEED constants for 8/16/32-bit widths
  - function `smear_mask(limit)`
- Sub-module lfsr_core (WIDTH, TAPS, SEED) holds the state register, step, load, and zero-guard.
- lfsr_rng wraps lfsr_core with the FSM, mask, and compare/fallback logic.

## Test plan
1. Reset, idle 3 cycles, advance=0 → lfsr_state=0x0001. advance=1 for 3 cycles → 0xB400, 0x5A00, 0x2D00.
2. Load seed 0x0001, request L=31 → rsp_data=1 at accept+2, state advances to 0xB400. Next request L=31 → rsp_data=0.
3. Load seed 0x0007, request L=4 (M=7) → C=7 rejected; state 0xB403, C=3 accepted; rsp_data=3 at accept+3.
4. MAX_TRY=1, seed 0x0007, L=4, with the second candidate forced >4 via TAPS=16'hB404 → fallback rsp_data=C−5, always ≤4. Also seed_in=0 loads 0x0001.
5. Hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_data stable, req_ready=0. Release → one transfer, req_ready=1 the next cycle.
6. Assert rst in DRAW → rsp_valid=0 and lfsr_state=0x0001 immediately. After release, a request completes normally. Randomised L: every rsp_data ≤ L.
